arr_multip: RTL and testbench

- 4x4 unsigned array multiplier with a registered 8-bit product output.
- Used as the array-multiplier candidate in the 4-bit adder/multiplier comparison datapath.
- Partial products are formed with AND gates and summed through a carry-save/ripple array of half- and full-adder cells.
- The result is captured in an output register on the rising clock edge.

---
 rtl/arr_multip.sv | 86 ++++++++
 tb/tb_arr_multip.sv | 89 ++++++++
 2 files changed

// File: rtl/arr_multip.sv
// 4x4 unsigned array multiplier: AND-gate partial products summed by HA/FA rows,
// product registered on the rising clock edge (1-cycle latency, no handshake).

module arr_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module arr_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module arr_multip (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] inp1,
    input  logic [3:0] inp2,
    output logic [7:0] product
);
    logic [3:0] pp   [4];
    logic [3:0] acc  [4];
    logic [3:0] sum  [1:3];
    logic [4:0] cy   [1:3];
    logic [7:0] product_d;
    logic [7:0] product_q;

    genvar r, b;
    generate
        for (r = 0; r < 4; r++) begin : g_pp
            for (b = 0; b < 4; b++) begin : g_bit
                assign pp[r][b] = inp1[b] & inp2[r];
            end
        end
    endgenerate

    // Each row adds the upper bits of the running sum to the next partial-product row;
    // the row's LSB retires as a final product bit and its carry-out enters the next row.
    assign acc[0] = {1'b0, pp[0][3:1]};

    generate
        for (r = 1; r < 4; r++) begin : g_row
            assign cy[r][0] = 1'b0;
            arr_ha u_ha (
                .a (acc[r-1][0]),
                .b (pp[r][0]),
                .s (sum[r][0]),
                .c (cy[r][1])
            );
            for (b = 1; b < 4; b++) begin : g_fa
                arr_fa u_fa (
                    .a  (acc[r-1][b]),
                    .b  (pp[r][b]),
                    .ci (cy[r][b]),
                    .s  (sum[r][b]),
                    .co (cy[r][b+1])
                );
            end
            assign acc[r] = {cy[r][4], sum[r][3:1]};
        end
    endgenerate

    assign product_d = {acc[3], sum[3][0], sum[2][0], sum[1][0], pp[0][0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            product_q <= 8'h00;
        end else begin
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_arr_multip.sv
// Directed and exhaustive check of arr_multip against hand-computed products.
module tb_arr_multip;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] inp1;
    logic [3:0] inp2;
    logic [7:0] product;
    int         vectors = 0;
    int         miscompares = 0;
    int         wide;

    arr_multip dut (
        .clk     (clk),
        .rst     (rst),
        .inp1    (inp1),
        .inp2    (inp2),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] exp);
        vectors++;
        assert (product === exp) else begin
            miscompares++;
            $error("FAIL %s: product=%0d expected=%0d", tag, product, exp);
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] b);
        inp1 = a;
        inp2 = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        inp1 = 4'd15;
        inp2 = 4'd15;
        @(posedge clk); #1;
        chk("reset_edge1", 8'h00);
        @(posedge clk); #1;
        chk("reset_edge2", 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_15x15", 8'd225);

        step(4'd10, 4'd12); chk("10x12", 8'd120);
        step(4'd13, 4'd12); chk("13x12", 8'd156);
        wide = 22;
        step(4'd10, wide[3:0]); chk("10x22trunc", 8'd60);
        step(4'd11, wide[3:0]); chk("11x22trunc", 8'd66);
        step(4'd12, 4'd15); chk("12x15", 8'd180);

        step(4'd0, 4'd13); chk("0x13", 8'd0);
        step(4'd9, 4'd0);  chk("9x0", 8'd0);
        step(4'd1, 4'd14); chk("1x14", 8'd14);
        step(4'd7, 4'd1);  chk("7x1", 8'd7);

        step(4'd3, 4'd5);  chk("hold_3x5", 8'd15);
        #3;
        inp1 = 4'd4;
        inp2 = 4'd4;
        #1;
        chk("hold_midcycle", 8'd15);
        @(posedge clk); #1;
        chk("hold_4x4", 8'd16);

        step(4'd12, 4'd15); chk("mid_12x15", 8'd180);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset", 8'd0);
        rst = 1'b0;
        step(4'd2, 4'd3); chk("mid_2x3", 8'd6);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [7:0] e;
                e = 8'(i * j);
                step(4'(i), 4'(j));
                chk("exhaustive", e);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
